// File: rtl/comp_minmax_scan.sv
// Frame min/max scanner: walks a DEPTH-word frame and reports the largest and
// smallest word together with the index where each first appears.

// Unsigned n-bit magnitude comparator.
module comp_nbit #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         gt,
    output logic         eq,
    output logic         lt
);
    // Pure combinational compare of two unsigned words.
    always_comb begin
        gt = (a > b);
        eq = (a == b);
        lt = (a < b);
    end
endmodule

module comp_minmax_scan #(
    parameter  int n     = 4,
    parameter  int DEPTH = 8,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          din_valid,
    input  logic [n-1:0]  din,
    output logic          busy,
    output logic          done,
    output logic [n-1:0]  max_val,
    output logic [IW-1:0] max_idx,
    output logic [n-1:0]  min_val,
    output logic [IW-1:0] min_idx
);
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    state_t        state;
    logic [IW-1:0] count;
    logic [n-1:0]  run_max, run_min;
    logic [IW-1:0] run_max_idx, run_min_idx;

    logic [n-1:0]  nx_max, nx_min;
    logic [IW-1:0] nx_max_idx, nx_min_idx;
    logic          max_gt, max_eq, max_lt;
    logic          min_gt, min_eq, min_lt;
    logic          last_word;

    // Only gt on the max side and lt on the min side matter; ties keep the
    // earlier index, so eq is deliberately ignored.
    logic unused_cmp;
    assign unused_cmp = ^{max_eq, max_lt, min_gt, min_eq};

    comp_nbit #(.n(n)) u_cmp_max (
        .a  (din),
        .b  (run_max),
        .gt (max_gt),
        .eq (max_eq),
        .lt (max_lt)
    );

    comp_nbit #(.n(n)) u_cmp_min (
        .a  (din),
        .b  (run_min),
        .gt (min_gt),
        .eq (min_eq),
        .lt (min_lt)
    );

    assign last_word = (count == IW'(DEPTH - 1));

    // Next running extremes if the current word is accepted; word 0 seeds both.
    always_comb begin
        nx_max     = run_max;
        nx_max_idx = run_max_idx;
        nx_min     = run_min;
        nx_min_idx = run_min_idx;
        if (count == '0) begin
            nx_max     = din;
            nx_max_idx = '0;
            nx_min     = din;
            nx_min_idx = '0;
        end else begin
            if (max_gt) begin
                nx_max     = din;
                nx_max_idx = count;
            end
            if (min_lt) begin
                nx_min     = din;
                nx_min_idx = count;
            end
        end
    end

    // Frame sequencer; result registers load only when the frame completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            run_max     <= '0;
            run_min     <= '0;
            run_max_idx <= '0;
            run_min_idx <= '0;
            max_val     <= '0;
            max_idx     <= '0;
            min_val     <= '0;
            min_idx     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_COLLECT;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (din_valid) begin
                        run_max     <= nx_max;
                        run_max_idx <= nx_max_idx;
                        run_min     <= nx_min;
                        run_min_idx <= nx_min_idx;
                        if (last_word) begin
                            state   <= S_DONE;
                            count   <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            max_val <= nx_max;
                            max_idx <= nx_max_idx;
                            min_val <= nx_min;
                            min_idx <= nx_min_idx;
                        end else begin
                            count <= count + IW'(1);
                        end
                    end
                end
                S_DONE: begin
                    // Start here chains straight into the next frame.
                    if (start) begin
                        state <= S_COLLECT;
                        count <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
